// File: rtl/imem_boot_loader.sv
// Boot-time program loader: streams 32-bit words from a boot source into the
// instruction memory, then releases memory ready and, after a delay, CPU run.
module imem_boot_loader #(
  parameter int MAX_WORDS   = 256,
  parameter int CNT_W       = 9,
  parameter int START_DELAY = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_boot_start,
  input  logic             i_src_valid,
  input  logic [31:0]      i_src_data,
  input  logic             i_src_last,
  output logic             o_src_ready,
  output logic [31:0]      o_mem_store,
  output logic             o_mem_load,
  output logic [31:0]      o_mem_wr_addr,
  output logic             o_mem_ready,
  output logic             o_cpu_run,
  output logic [CNT_W-1:0] o_words_loaded,
  output logic             o_overflow
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FINISH, S_RUN, S_ERR} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_WORDS - 1);
  localparam logic [3:0]       DLY_END  = 4'(START_DELAY - 1);
  localparam logic [3:0]       DLY_MAX  = 4'(START_DELAY);

  state_t           r_state, w_state_nxt;
  logic             w_xfer;
  logic             w_last_slot;
  logic [31:0]      r_mem_store;
  logic [31:0]      r_mem_wr_addr;
  logic             r_mem_load;
  logic             r_mem_ready;
  logic             r_cpu_run;
  logic             r_overflow;
  logic [CNT_W-1:0] r_words_loaded;
  logic [3:0]       r_dly;

  assign w_xfer      = i_src_valid & o_src_ready;
  assign w_last_slot = (r_words_loaded == LAST_IDX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // A word without src_last that fills the last slot is an overflow; src_last wins.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (i_boot_start) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (w_xfer) begin
          if (i_src_last)       w_state_nxt = S_FINISH;
          else if (w_last_slot) w_state_nxt = S_ERR;
        end
      end
      S_FINISH: w_state_nxt = S_RUN;
      default:  w_state_nxt = r_state;
    endcase
  end

  always_comb begin
    o_src_ready = (r_state == S_LOAD);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_store    <= '0;
      r_mem_wr_addr  <= '0;
      r_mem_load     <= 1'b0;
      r_words_loaded <= '0;
      r_mem_ready    <= 1'b0;
      r_overflow     <= 1'b0;
      r_dly          <= '0;
      r_cpu_run      <= 1'b0;
    end else begin
      r_mem_load <= w_xfer;
      if (w_xfer) begin
        r_mem_store    <= i_src_data;
        r_mem_wr_addr  <= 32'({r_words_loaded, 2'b00});
        r_words_loaded <= r_words_loaded + CNT_W'(1);
      end
      r_mem_ready <= (w_state_nxt == S_RUN);
      r_overflow  <= (w_state_nxt == S_ERR);
      // Delay counter saturates once cpu_run has been released.
      if (r_state == S_RUN && r_dly != DLY_MAX) r_dly <= r_dly + 4'd1;
      if (r_state == S_RUN && r_dly == DLY_END) r_cpu_run <= 1'b1;
    end
  end

  assign o_mem_store    = r_mem_store;
  assign o_mem_wr_addr  = r_mem_wr_addr;
  assign o_mem_load     = r_mem_load;
  assign o_words_loaded = r_words_loaded;
  assign o_mem_ready    = r_mem_ready;
  assign o_cpu_run      = r_cpu_run;
  assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: a full-size instance and an 8-word instance
// share stimulus; outputs are compared to a table and to an event-time model.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        boot = 1'b0, valid = 1'b0, last = 1'b0;
  logic [31:0] data = '0;

  logic        b_ready, b_load, b_mready, b_run, b_ovf;
  logic [31:0] b_store, b_addr;
  logic [8:0]  b_words;
  logic        s_ready, s_load, s_mready, s_run, s_ovf;
  logic [31:0] s_store, s_addr;
  logic [8:0]  s_words;

  imem_boot_loader #(.MAX_WORDS(256), .CNT_W(9), .START_DELAY(2)) u_big (
    .i_clk(clk), .i_rst_n(rst_n), .i_boot_start(boot), .i_src_valid(valid),
    .i_src_data(data), .i_src_last(last), .o_src_ready(b_ready),
    .o_mem_store(b_store), .o_mem_load(b_load), .o_mem_wr_addr(b_addr),
    .o_mem_ready(b_mready), .o_cpu_run(b_run), .o_words_loaded(b_words),
    .o_overflow(b_ovf));

  imem_boot_loader #(.MAX_WORDS(8), .CNT_W(9), .START_DELAY(1)) u_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_boot_start(boot), .i_src_valid(valid),
    .i_src_data(data), .i_src_last(last), .o_src_ready(s_ready),
    .o_mem_store(s_store), .o_mem_load(s_load), .o_mem_wr_addr(s_addr),
    .o_mem_ready(s_mready), .o_cpu_run(s_run), .o_words_loaded(s_words),
    .o_overflow(s_ovf));

  always #5 clk = ~clk;

  bit sel = 1'b0;
  logic        a_ready, a_load, a_mready, a_run, a_ovf;
  logic [31:0] a_store, a_addr;
  logic [8:0]  a_words;
  assign a_ready  = sel ? s_ready  : b_ready;
  assign a_load   = sel ? s_load   : b_load;
  assign a_mready = sel ? s_mready : b_mready;
  assign a_run    = sel ? s_run    : b_run;
  assign a_ovf    = sel ? s_ovf    : b_ovf;
  assign a_store  = sel ? s_store  : b_store;
  assign a_addr   = sel ? s_addr   : b_addr;
  assign a_words  = sel ? s_words  : b_words;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
    end
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_ready_b"}, 32'(b_ready), 0);  chk({tag, "_ready_s"}, 32'(s_ready), 0);
    chk({tag, "_load_b"}, 32'(b_load), 0);    chk({tag, "_load_s"}, 32'(s_load), 0);
    chk({tag, "_store_b"}, b_store, 0);       chk({tag, "_store_s"}, s_store, 0);
    chk({tag, "_addr_b"}, b_addr, 0);         chk({tag, "_addr_s"}, s_addr, 0);
    chk({tag, "_words_b"}, 32'(b_words), 0);  chk({tag, "_words_s"}, 32'(s_words), 0);
    chk({tag, "_mready_b"}, 32'(b_mready), 0); chk({tag, "_mready_s"}, 32'(s_mready), 0);
    chk({tag, "_run_b"}, 32'(b_run), 0);      chk({tag, "_run_s"}, 32'(s_run), 0);
    chk({tag, "_ovf_b"}, 32'(b_ovf), 0);      chk({tag, "_ovf_s"}, 32'(s_ovf), 0);
  endtask

  // Event-time model: every output is a function of when boot, accepts and
  // the terminating accept happened, relative to the current cycle.
  int          m_cyc, m_boot, m_end, m_last_acc, m_nacc;
  bit          m_ok;
  logic [31:0] m_data;

  task automatic mdl_reset();
    m_cyc = 0; m_boot = -1; m_end = -1; m_last_acc = -100; m_nacc = 0;
    m_ok = 1'b0; m_data = '0;
  endtask

  task automatic step(input logic b, input logic v, input logic [31:0] d, input logic l);
    int maxw, dly;
    bit er, el;
    @(negedge clk);
    maxw = sel ? 8 : 256;
    dly  = sel ? 1 : 2;
    er = (m_boot >= 0) && (m_cyc > m_boot) && (m_end < 0);
    el = (m_last_acc == m_cyc - 1);
    chk("src_ready", 32'(a_ready), 32'(er));
    chk("mem_load", 32'(a_load), 32'(el));
    chk("words_loaded", 32'(a_words), 32'(m_nacc));
    if (el) begin
      chk("mem_store", a_store, m_data);
      chk("mem_wr_addr", a_addr, 32'((m_nacc - 1) * 4));
    end
    chk("mem_ready", 32'(a_mready), 32'(m_ok && m_end >= 0 && m_cyc >= m_end + 2));
    chk("cpu_run", 32'(a_run), 32'(m_ok && m_end >= 0 && m_cyc >= m_end + 2 + dly));
    chk("overflow", 32'(a_ovf), 32'(!m_ok && m_end >= 0 && m_cyc >= m_end + 1));
    boot = b; valid = v; data = d; last = l;
    if (v && er) begin
      m_nacc++; m_data = d; m_last_acc = m_cyc;
      if (l) begin m_end = m_cyc; m_ok = 1'b1; end
      else if (m_nacc == maxw) begin m_end = m_cyc; m_ok = 1'b0; end
    end
    if (b && m_boot < 0) m_boot = m_cyc;
    m_cyc++;
  endtask

  task automatic hold_reset();
    boot = 1'b0; valid = 1'b0; data = '0; last = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_reset();
  endtask

  typedef struct {
    logic        b, v; logic [31:0] d; logic l;
    logic        rdy, ld; logic [31:0] addr, st; logic [8:0] w; logic mr, run;
  } tv_t;

  function automatic tv_t mk(logic b, logic v, logic [31:0] d, logic l, logic rdy, logic ld,
                             logic [31:0] addr, logic [31:0] st, logic [8:0] w, logic mr, logic run);
    tv_t t;
    t.b = b; t.v = v; t.d = d; t.l = l; t.rdy = rdy; t.ld = ld;
    t.addr = addr; t.st = st; t.w = w; t.mr = mr; t.run = run;
    return t;
  endfunction

  localparam logic [31:0] W0 = 32'h20080005, W1 = 32'h20090003,
                          W2 = 32'h01095020, W3 = 32'hAC0A0000;

  initial begin
    tv_t tbl[11];
    int len, npre;
    tbl[0]  = mk(1, 0, 0,            0, 0, 0, 0,  0,  0, 0, 0);
    tbl[1]  = mk(0, 1, W0,           0, 1, 0, 0,  0,  0, 0, 0);
    tbl[2]  = mk(0, 1, W1,           0, 1, 1, 0,  W0, 1, 0, 0);
    tbl[3]  = mk(0, 1, W2,           0, 1, 1, 4,  W1, 2, 0, 0);
    tbl[4]  = mk(0, 1, W3,           1, 1, 1, 8,  W2, 3, 0, 0);
    tbl[5]  = mk(0, 0, 0,            0, 0, 1, 12, W3, 4, 0, 0);
    tbl[6]  = mk(0, 0, 0,            0, 0, 0, 12, W3, 4, 1, 0);
    tbl[7]  = mk(0, 0, 0,            0, 0, 0, 12, W3, 4, 1, 0);
    tbl[8]  = mk(1, 1, 32'hDEADBEEF, 1, 0, 0, 12, W3, 4, 1, 1);
    tbl[9]  = mk(0, 0, 0,            0, 0, 0, 12, W3, 4, 1, 1);
    tbl[10] = mk(0, 0, 0,            0, 0, 0, 12, W3, 4, 1, 1);

    #2 zero_chk("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed image: back-to-back load, then boot/valid poked during RUN
    sel = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), 32'(b_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_load", i), 32'(b_load), 32'(tbl[i].ld));
      chk($sformatf("tbl%0d_addr", i), b_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_store", i), b_store, tbl[i].st);
      chk($sformatf("tbl%0d_words", i), 32'(b_words), 32'(tbl[i].w));
      chk($sformatf("tbl%0d_mready", i), 32'(b_mready), 32'(tbl[i].mr));
      chk($sformatf("tbl%0d_run", i), 32'(b_run), 32'(tbl[i].run));
      chk($sformatf("tbl%0d_ovf", i), 32'(b_ovf), 0);
      boot = tbl[i].b; valid = tbl[i].v; data = tbl[i].d; last = tbl[i].l;
    end

    // Same image with src_valid toggling
    hold_reset();
    step(1, 0, 0, 0);
    step(0, 1, W0, 0); step(0, 0, 0, 0); step(0, 1, W1, 0); step(0, 0, 0, 0);
    step(0, 1, W2, 0); step(0, 0, 0, 0); step(0, 1, W3, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0);

    // src_valid before boot_start is ignored
    hold_reset();
    for (int i = 0; i < 3; i++) step(0, 1, $urandom, 0);
    step(1, 1, $urandom, 0);
    step(0, 1, W0, 0); step(0, 1, W1, 0); step(0, 1, W2, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

    // 8-word instance: overflow, then src_last exactly on the 8th word
    sel = 1'b1;
    hold_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, $urandom, 0);
    for (int i = 0; i < 6; i++) step(i[0], 1, $urandom, 1);
    hold_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, $urandom, (i == 7) ? 1'b1 : 1'b0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);

    // Asynchronous reset between edges after 3 accepted words
    sel = 1'b0;
    hold_reset();
    step(1, 0, 0, 0);
    step(0, 1, W0, 0); step(0, 1, W1, 0); step(0, 1, W2, 0); step(0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1 zero_chk("midrst");
    hold_reset();
    step(1, 0, 0, 0);
    step(0, 1, W3, 0); step(0, 1, W0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

    // Randomized images on both instances, with noise on boot/valid throughout
    for (int img = 0; img < 12; img++) begin
      sel = img[0];
      hold_reset();
      len  = sel ? $urandom_range(1, 10) : $urandom_range(1, 24);
      npre = $urandom_range(0, 3);
      for (int i = 0; i < npre; i++) step(0, $urandom_range(0, 1), $urandom, 0);
      step(1, $urandom_range(0, 1), $urandom, 0);
      for (int g = 0; g < 400 && m_end < 0; g++)
        step(($urandom % 8) == 0, ($urandom % 4) != 0, $urandom,
             (m_nacc == len - 1) ? 1'b1 : 1'b0);
      for (int i = 0; i < 6; i++) step($urandom_range(0, 1), $urandom_range(0, 1), $urandom, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
